// File: rtl/grid_io_param_pkg.sv
// Shared constants and helpers for the I/O grid tile configuration chain.
package grid_io_param_pkg;

  // Bit positions inside one subtile's configuration field.
  localparam int CFG_OE_BIT = 0;
  localparam int CFG_IE_BIT = 1;

  // Total length of the serial configuration chain.
  function automatic int chain_len(input int num_subtiles, input int cfg_bits);
    return num_subtiles * cfg_bits;
  endfunction

endpackage

// File: rtl/grid_io_param_if.sv
// Serial configuration chain bundle: data in/out, shift/commit controls, status.
interface grid_io_param_if;

  logic ccff_head;
  logic ccff_shift_en;
  logic ccff_commit;
  logic ccff_tail;
  logic cfg_done;
  logic cfg_err;

  // Side that loads the chain (previous tile or configuration controller).
  modport master (
    output ccff_head,
    output ccff_shift_en,
    output ccff_commit,
    input  ccff_tail,
    input  cfg_done,
    input  cfg_err
  );

  // Side that owns the chain (the tile itself).
  modport slave (
    input  ccff_head,
    input  ccff_shift_en,
    input  ccff_commit,
    output ccff_tail,
    output cfg_done,
    output cfg_err
  );

endinterface

// File: rtl/grid_io_param_pad.sv
// One I/O subtile: tri-state pad driver plus gated input path to the fabric.
module grid_io_param_pad (
  input  logic oe,
  input  logic ie,
  input  logic outpad,
  output logic inpad,
  inout  wire  pad
);

  assign pad   = oe ? outpad : 1'bz;
  // With both enables set the pad reads back our own drive (loopback).
  assign inpad = ie ? pad : 1'b0;

endmodule

// File: rtl/grid_io_param.sv
// I/O grid tile: serial shadow configuration chain with checked commit into an
// active register that steers NUM_SUBTILES tri-state pads.
module grid_io_param
  import grid_io_param_pkg::*;
#(
  parameter int NUM_SUBTILES = 8,  // 1..64
  parameter int CFG_BITS     = 2   // >= 2; bits above CFG_IE_BIT are reserved
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  grid_io_param_if.slave          cfg,
  input  logic [NUM_SUBTILES-1:0] io_outpad,
  output logic [NUM_SUBTILES-1:0] io_inpad,
  inout  wire  [NUM_SUBTILES-1:0] gfpga_pad_GPIO_PAD
);

  localparam int CHAIN_LEN = chain_len(NUM_SUBTILES, CFG_BITS);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     count;
  logic                 err_q;
  logic                 full;

  assign full = (count == CNT_FULL);

  // Shadow chain, shift counter, commit check and active configuration.
  // Commit wins over a simultaneous shift so the validated image is what loads.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shadow <= '0;
      active <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else if (cfg.ccff_commit) begin
      count <= '0;
      if (full) begin
        active <= shadow;
        err_q  <= 1'b0;
      end else begin
        err_q  <= 1'b1;
      end
    end else if (cfg.ccff_shift_en) begin
      shadow <= {shadow[CHAIN_LEN-2:0], cfg.ccff_head};
      // Saturating one past full keeps an over-length load distinguishable.
      if (count != CNT_SAT) begin
        count <= count + 1'b1;
      end
    end
  end

  assign cfg.ccff_tail = shadow[CHAIN_LEN-1];
  assign cfg.cfg_done  = full;
  assign cfg.cfg_err   = err_q;

  // Reserved configuration bits are stored but have no effect.
  logic unused_reserved;
  assign unused_reserved = ^active;

  for (genvar i = 0; i < NUM_SUBTILES; i++) begin : g_pad
    grid_io_param_pad u_pad (
      .oe     (active[i*CFG_BITS + CFG_OE_BIT]),
      .ie     (active[i*CFG_BITS + CFG_IE_BIT]),
      .outpad (io_outpad[i]),
      .inpad  (io_inpad[i]),
      .pad    (gfpga_pad_GPIO_PAD[i])
    );
  end

endmodule
